// File: rtl/logic_arbiter_pkg.sv
// logic_arbiter_pkg: shared widths and op encodings for logic_arbiter.
// DATA_W comes from `REG_WIDTH (default 32).
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
package logic_arbiter_pkg;
    localparam int REG_W         = `REG_WIDTH;
    localparam int LOGIC_OP_W    = 3;
    localparam int NUM_LOGIC_OPS = 5;
    typedef enum logic [LOGIC_OP_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_NOR = 3'b010,
        ALU_XOR = 3'b011,
        ALU_SLT = 3'b100
    } logic_op_e;
    function automatic logic op_legal(input logic [LOGIC_OP_W-1:0] op);
        return op <= ALU_SLT;
    endfunction
endpackage

// File: rtl/logic_arbiter_alu.sv
// logic_arbiter_alu: combinational AND/OR/NOR/XOR/unsigned-SLT unit; illegal ops yield 0.
module logic_arbiter_alu
    import logic_arbiter_pkg::*;
#(
    parameter int DATA_W = REG_W
) (
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [LOGIC_OP_W-1:0] op,
    output logic [DATA_W-1:0]     result
);
    always_comb begin
        result = op == ALU_AND ? a & b :
                 op == ALU_OR  ? a | b :
                 op == ALU_NOR ? ~(a | b) :
                 op == ALU_XOR ? a ^ b :
                 op == ALU_SLT ? {{(DATA_W-1){1'b0}}, a < b} : '0;
    end
endmodule

// File: rtl/logic_arbiter.sv
// logic_arbiter: round-robin sharing of one logic unit between two requesters, one registered result stage.
// Optional LOGIC_ARB_ERR_EN adds rsp_err flagging results of illegal ops.
module logic_arbiter
    import logic_arbiter_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    input  logic [LOGIC_OP_W-1:0] req0_op,
    input  logic [TAG_W-1:0]      req0_tag,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    input  logic [LOGIC_OP_W-1:0] req1_op,
    input  logic [TAG_W-1:0]      req1_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_result,
    output logic                  rsp_src,
    output logic [TAG_W-1:0]      rsp_tag
`ifdef LOGIC_ARB_ERR_EN
    ,
    output logic                  rsp_err
`endif
);
    logic                  last_grant;
    logic                  grant0;
    logic                  grant1;
    logic                  can_load;
    logic                  accept;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [DATA_W-1:0]     result;
    logic [LOGIC_OP_W-1:0] op;
    logic [TAG_W-1:0]      tag;
    // Grant depends on valids only; last_grant moves on accept so a stalled grant holds.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        can_load   = ~rsp_valid | rsp_ready;
        req0_ready = grant0 & can_load;
        req1_ready = grant1 & can_load;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        a          = grant1 ? req1_a : req0_a;
        b          = grant1 ? req1_b : req0_b;
        op         = grant1 ? req1_op : req0_op;
        tag        = grant1 ? req1_tag : req0_tag;
    end
    logic_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_src    <= 1'b0;
            rsp_tag    <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_result <= result;
            rsp_src    <= grant1;
            rsp_tag    <= tag;
            last_grant <= grant1;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end
`ifdef LOGIC_ARB_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            rsp_err <= 1'b0;
        else if (accept)
            rsp_err <= ~op_legal(op);
    end
`endif
endmodule
